// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a registered output stage and a one-entry skid buffer.
// Accepts one instruction per cycle under backpressure, in order, with a sideband tag per entry.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int TAG_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_inst,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic             out_illegal,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [2:0] {
        FMT_NONE  = 3'd0,
        FMT_I     = 3'd1,
        FMT_S     = 3'd2,
        FMT_B     = 3'd3,
        FMT_U     = 3'd4,
        FMT_J     = 3'd5,
        FMT_ZIMM  = 3'd6,
        FMT_SHAMT = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic             illegal;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [63:0] imm_w;
    fmt_e        dec_fmt;
    logic        dec_ill;
    entry_t      new_entry;

    assign op = in_inst[6:0];
    assign f3 = in_inst[14:12];

    // Immediates are built at 64 bits and truncated, so one decoder serves both XLEN values.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        imm_w   = '0;
        dec_fmt = FMT_NONE;
        dec_ill = 1'b0;
        if (in_inst[1:0] != 2'b11) begin
            dec_ill = 1'b1;
        end else begin
            unique case (op)
                7'b0000011, 7'b1100111: begin
                    dec_fmt = FMT_I;
                    imm_w   = {{52{in_inst[31]}}, in_inst[31:20]};
                end
                7'b0010011: begin
                    if (f3 == 3'b001 || f3 == 3'b101) begin
                        dec_fmt = FMT_SHAMT;
                        if (XLEN == 64) begin
                            imm_w = {58'b0, in_inst[25:20]};
                        end else begin
                            imm_w   = {59'b0, in_inst[24:20]};
                            dec_ill = in_inst[25];
                        end
                    end else begin
                        dec_fmt = FMT_I;
                        imm_w   = {{52{in_inst[31]}}, in_inst[31:20]};
                    end
                end
                7'b0011011: begin
                    if (XLEN != 64) begin
                        dec_ill = 1'b1;
                    end else if (f3 == 3'b001 || f3 == 3'b101) begin
                        dec_fmt = FMT_SHAMT;
                        imm_w   = {59'b0, in_inst[24:20]};
                    end else begin
                        dec_fmt = FMT_I;
                        imm_w   = {{52{in_inst[31]}}, in_inst[31:20]};
                    end
                end
                7'b0100011: begin
                    dec_fmt = FMT_S;
                    imm_w   = {{52{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
                end
                7'b1100011: begin
                    dec_fmt = FMT_B;
                    imm_w   = {{51{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                               in_inst[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec_fmt = FMT_U;
                    imm_w   = {{32{in_inst[31]}}, in_inst[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec_fmt = FMT_J;
                    imm_w   = {{43{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                               in_inst[30:21], 1'b0};
                end
                7'b1110011: begin
                    if (f3[2]) begin
                        dec_fmt = FMT_ZIMM;
                        imm_w   = {59'b0, in_inst[19:15]};
                    end
                end
                7'b0110011, 7'b0111011, 7'b0001111: ;
                default: dec_ill = 1'b1;
            endcase
        end
        new_entry = '{imm: imm_w[XLEN-1:0], fmt: dec_fmt, illegal: dec_ill, tag: in_tag};
    end

    entry_t main_q, skid_q;
    logic   main_valid, skid_valid;
    logic   load_skid;

    // Skid only fills when main is stalled; it empties into main on the next drain.
    assign load_skid = !flush && main_valid && !out_ready && in_valid && !skid_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= '0;
        end else if (flush) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!main_valid || out_ready) begin
            if (skid_valid) begin
                main_q     <= skid_q;
                main_valid <= 1'b1;
                skid_valid <= 1'b0;
            end else if (in_valid) begin
                main_q     <= new_entry;
                main_valid <= 1'b1;
            end else begin
                main_valid <= 1'b0;
            end
        end else if (load_skid) begin
            skid_valid <= 1'b1;
        end
    end

    // NOTE: skid payload has no reset; skid_valid alone decides whether it is ever observed.
    always_ff @(posedge clk) begin
        if (load_skid) skid_q <= new_entry;
    end

    assign in_ready    = !skid_valid;
    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_tag     = main_q.tag;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=64 instance checked fully, XLEN=32 twin checked
// for imm/illegal on the same stream.
module tb_imm_gen_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready, in_ready32;
    logic [31:0] in_inst;
    logic [31:0] in_tag;
    logic        out_valid, out_valid32;
    logic        out_ready;
    logic [63:0] out_imm;
    logic [31:0] out_imm32;
    logic [2:0]  out_fmt, out_fmt32;
    logic        out_illegal, out_illegal32;
    logic [31:0] out_tag, out_tag32;

    always #5 clk = ~clk;

    imm_gen_pipe #(.XLEN(64), .TAG_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
        .out_fmt(out_fmt), .out_illegal(out_illegal), .out_tag(out_tag)
    );

    imm_gen_pipe #(.XLEN(32), .TAG_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready32), .in_inst(in_inst), .in_tag(in_tag),
        .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
        .out_fmt(out_fmt32), .out_illegal(out_illegal32), .out_tag(out_tag32)
    );

    typedef struct {
        logic [31:0] tag;
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic        ill;
        logic [31:0] imm32;
        logic        ill32;
    } exp_t;

    exp_t q[$];
    exp_t pend;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", name, obs, exp);
        end
    endtask

    task automatic set_in(input logic [31:0] inst, input logic [31:0] tag,
                          input logic [63:0] imm, input logic [2:0] fmt, input logic ill,
                          input logic [31:0] imm32, input logic ill32);
        in_valid   = 1'b1;
        in_inst    = inst;
        in_tag     = tag;
        pend.tag   = tag;
        pend.imm   = imm;
        pend.fmt   = fmt;
        pend.ill   = ill;
        pend.imm32 = imm32;
        pend.ill32 = ill32;
    endtask

    // Called just after a negedge: compare outputs against the scoreboard head, then model
    // the coming clock edge on the scoreboard and advance to the next negedge.
    task automatic cycle();
        check("out_valid_vs_sb", 64'(out_valid), 64'(q.size() != 0));
        if (out_valid && q.size() != 0) begin
            check("out_tag", 64'(out_tag), 64'(q[0].tag));
            check("out_imm", out_imm, q[0].imm);
            check("out_fmt", 64'(out_fmt), 64'(q[0].fmt));
            check("out_illegal", 64'(out_illegal), 64'(q[0].ill));
            check("imm_x32", 64'(out_imm32), 64'(q[0].imm32));
            check("illegal_x32", 64'(out_illegal32), 64'(q[0].ill32));
            if (out_ready && !flush) void'(q.pop_front());
        end
        if (in_valid && in_ready && !flush) q.push_back(pend);
        if (flush) q.delete();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  idx;
        bit  acc;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        #12;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_imm", out_imm, 64'd0);
        check("rst_out_fmt", 64'(out_fmt), 64'd0);
        check("rst_out_illegal", 64'(out_illegal), 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed decode vectors, streamed back to back with the consumer always ready.
        set_in(32'hFFF00093, 32'h1000, 64'hFFFFFFFF_FFFFFFFF, 3'd1, 1'b0, 32'hFFFFFFFF, 1'b0);
        cycle();
        check("latency1_valid", 64'(out_valid), 64'd1);
        set_in(32'hFE000EE3, 32'h1004, 64'hFFFFFFFF_FFFFFFFC, 3'd3, 1'b0, 32'hFFFFFFFC, 1'b0);
        cycle();
        set_in(32'h800002B7, 32'h1008, 64'hFFFFFFFF_80000000, 3'd4, 1'b0, 32'h80000000, 1'b0);
        cycle();
        set_in(32'h43F0D093, 32'h100C, 64'h3F, 3'd7, 1'b0, 32'h1F, 1'b1);
        cycle();
        set_in(32'h3002D073, 32'h1010, 64'h5, 3'd6, 1'b0, 32'h5, 1'b0);
        cycle();
        set_in(32'h0080006F, 32'h1014, 64'h8, 3'd5, 1'b0, 32'h8, 1'b0);
        cycle();
        set_in(32'hFE112E23, 32'h1018, 64'hFFFFFFFF_FFFFFFFC, 3'd2, 1'b0, 32'hFFFFFFFC, 1'b0);
        cycle();
        set_in(32'h00000001, 32'h101C, 64'h0, 3'd0, 1'b1, 32'h0, 1'b1);
        cycle();
        set_in(32'h00000033, 32'h1020, 64'h0, 3'd0, 1'b0, 32'h0, 1'b0);
        cycle();
        set_in(32'h0010109B, 32'h1024, 64'h1, 3'd7, 1'b0, 32'h0, 1'b1);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Backpressure: four tagged addi's, consumer stalled, then released.
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 4; c++) begin
            set_in(32'h00000013 | (32'(idx + 1) << 20), 32'h10 + 32'(idx),
                   64'(idx + 1), 3'd1, 1'b0, 32'(idx + 1), 1'b0);
            acc = in_ready;
            cycle();
            if (acc) idx++;
        end
        check("bp_accepts_before_stall", 64'(idx), 64'd2);
        check("bp_in_ready_low", 64'(in_ready), 64'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && (idx < 4 || q.size() != 0); c++) begin
            if (idx < 4)
                set_in(32'h00000013 | (32'(idx + 1) << 20), 32'h10 + 32'(idx),
                       64'(idx + 1), 3'd1, 1'b0, 32'(idx + 1), 1'b0);
            else
                in_valid = 1'b0;
            acc = in_valid && in_ready;
            cycle();
            if (acc) idx++;
        end
        check("bp_all_accepted", 64'(idx), 64'd4);
        check("bp_drained", 64'(q.size()), 64'd0);
        in_valid = 1'b0;
        cycle();

        // Flush with main and skid full and a new input presented.
        out_ready = 1'b0;
        set_in(32'h00100093, 32'h100, 64'h1, 3'd1, 1'b0, 32'h1, 1'b0);
        cycle();
        set_in(32'h00200093, 32'h101, 64'h2, 3'd1, 1'b0, 32'h2, 1'b0);
        cycle();
        check("pre_flush_in_ready", 64'(in_ready), 64'd0);
        set_in(32'h00300093, 32'h102, 64'h3, 3'd1, 1'b0, 32'h3, 1'b0);
        flush = 1'b1;
        cycle();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        set_in(32'h00400093, 32'h103, 64'h4, 3'd1, 1'b0, 32'h4, 1'b0);
        cycle();
        in_valid = 1'b0;
        cycle();
        cycle();

        // Asynchronous reset with two entries held, then a fresh instruction.
        out_ready = 1'b0;
        set_in(32'h00500093, 32'h200, 64'h5, 3'd1, 1'b0, 32'h5, 1'b0);
        cycle();
        set_in(32'h00600093, 32'h201, 64'h6, 3'd1, 1'b0, 32'h6, 1'b0);
        cycle();
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("mid_rst_out_valid", 64'(out_valid), 64'd0);
        check("mid_rst_out_imm", out_imm, 64'd0);
        check("mid_rst_out_tag", 64'(out_tag), 64'd0);
        check("mid_rst_in_ready", 64'(in_ready), 64'd1);
        q.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        set_in(32'h00700093, 32'h202, 64'h7, 3'd1, 1'b0, 32'h7, 1'b0);
        cycle();
        in_valid = 1'b0;
        check("post_rst_latency1", 64'(out_valid), 64'd1);
        cycle();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
